// File: rtl/xor_share_arb.sv
// xor_share_arb: two requesters share a single WIDTH-bit XOR datapath.
//
// The arbiter grants one operand pair at a time using round-robin order.
// It latches the operands and pushes them through the xorval datapath.
// The result is presented on a registered valid/ready port, tagged with
// the id of the requester that owns it.
//
// Each operation goes through three states:
//   IDLE  accept (arbitrate and latch the operands)
//   EXEC  compute (register the XOR result)
//   OUT   present (hold the result until the consumer takes it)
//
// Optional build macro XOR_SHARE_PARITY_EN:
//   Adds output res_parity. It is the reduction XOR of the registered
//   result and follows the same timing as res_data.

// Bitwise XOR datapath shared by both requesters.
module xorval #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] c_o
);

  assign c_o = a_i ^ b_i;

endmodule

module xor_share_arb #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  // result port
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id
`ifdef XOR_SHARE_PARITY_EN
  ,
  output logic             res_parity
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;   // id of the most recent grant
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_id_q, res_id_d;
`ifdef XOR_SHARE_PARITY_EN
  logic             res_parity_q, res_parity_d;
`endif

  logic             grant0, grant1;
  logic [WIDTH-1:0] xor_c;

  // Shared datapath works on the latched operands only, so operand
  // changes after the accepting edge cannot reach the result.
  xorval #(.WIDTH(WIDTH)) u_xorval (
    .a_i (a_q),
    .b_i (b_q),
    .c_o (xor_c)
  );

  // Round-robin grant: a lone valid request wins outright. On a tie,
  // the requester that was not served last time wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      grant0 = req0_valid && (!req1_valid || last_q);
      grant1 = req1_valid && (!req0_valid || !last_q);
    end
  end

  // Next-state and next-register logic for the accept/compute/present FSM.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // can leave it unassigned and infer a latch.
    state_d     = state_q;
    last_d      = last_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
`ifdef XOR_SHARE_PARITY_EN
    res_parity_d = res_parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant0) begin
          a_d     = req0_a;
          b_d     = req0_b;
          id_d    = 1'b0;
          last_d  = 1'b0;
          state_d = EXEC;
        end else if (grant1) begin
          a_d     = req1_a;
          b_d     = req1_b;
          id_d    = 1'b1;
          last_d  = 1'b1;
          state_d = EXEC;
        end
      end

      EXEC: begin
        res_data_d  = xor_c;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
`ifdef XOR_SHARE_PARITY_EN
        res_parity_d = ^xor_c;
`endif
        state_d     = OUT;
      end

      OUT: begin
        // Data and id stay put after the handshake. Only valid drops.
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register here, including the operand registers, has a
      // defined reset value. A result therefore never exposes stale data
      // after reset.
      state_q     <= IDLE;
      last_q      <= 1'b1;   // so requester 0 wins the first tie
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
`ifdef XOR_SHARE_PARITY_EN
      res_parity_q <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so all
      // registers update together from the values held before the edge.
      state_q     <= state_d;
      last_q      <= last_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
`ifdef XOR_SHARE_PARITY_EN
      res_parity_q <= res_parity_d;
`endif
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_id     = res_id_q;
`ifdef XOR_SHARE_PARITY_EN
  assign res_parity = res_parity_q;
`endif

endmodule
